// File: rtl/hwpf_stride_pkg.sv
// ============================================================================
// Module      : hwpf_stride_pkg
// Description : Shared types and constants for the stride prefetcher request
//               arbiter: engine count default, engine id type, a minimal
//               HPDcache configuration record and default cache request and
//               response structures.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hwpf_stride_pkg;

    // Default number of stride prefetch engines sharing the cache port.
    localparam int unsigned HWPF_NUM_DEFAULT = 4;

    // Width of an engine index for n engines; at least one bit.
    function automatic int unsigned hwpf_id_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned HWPF_ENGINE_ID_W = hwpf_id_width(HWPF_NUM_DEFAULT);
    typedef logic [HWPF_ENGINE_ID_W-1:0] hwpf_engine_id_t;

    // Cache-side geometry used by the default request/response types.
    localparam int unsigned HPDCACHE_TID_W   = 3;
    localparam int unsigned HPDCACHE_NLINE_W = 26;

    typedef struct packed {
        int unsigned tidWidth;
    } hpdcache_cfg_t;

    localparam hpdcache_cfg_t HPDCACHE_CFG_DEFAULT = '{tidWidth: HPDCACHE_TID_W};

    typedef logic [HPDCACHE_TID_W-1:0] hpdcache_tid_t;

    typedef struct packed {
        logic [HPDCACHE_NLINE_W-1:0] nline;
        logic [1:0]                  op;
        hpdcache_tid_t               tid;
    } hwpf_cache_req_t;

    typedef struct packed {
        logic [31:0]   data;
        logic          error;
        hpdcache_tid_t tid;
    } hwpf_cache_rsp_t;

endpackage

`default_nettype wire

// File: rtl/hwpf_stride_rr_arb.sv
// ============================================================================
// Module      : hwpf_stride_rr_arb
// Description : Generic N-way round-robin arbiter. The winner is the first
//               requester found scanning upward from ptr+1 (wrapping). The
//               pointer moves to the winner only when a grant is issued.
// Ports       : clk_i, rst_ni   - clock, async active-low reset
//               req_i           - request vector
//               en_i            - grant enable (downstream can accept)
//               gnt_o           - one-hot grant (zero when disabled/idle)
//               gnt_idx_o       - index of the current winner
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hwpf_stride_rr_arb
    import hwpf_stride_pkg::*;
#(
    parameter int unsigned NUM_REQ = HWPF_NUM_DEFAULT,
    parameter int unsigned IDX_W   = hwpf_id_width(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] w_win_idx;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    // Scan ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); first requester wins.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = ptr_q;
        w_cand    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!w_found && req_i[w_cand]) begin
                w_found   = 1'b1;
                w_win_idx = w_cand;
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        if (w_found && en_i) begin
            gnt_o[w_win_idx] = 1'b1;
        end
    end

    assign gnt_idx_o = w_win_idx;
    assign ptr_d     = (w_found && en_i) ? w_win_idx : ptr_q;

    // Reset to the last index so requester 0 has first priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hwpf_stride_req_arb.sv
// ============================================================================
// Module      : hwpf_stride_req_arb
// Description : Arbitrates the requests of NUM_HW_PREFETCH stride prefetch
//               engines onto the single HPDcache prefetch port through a
//               one-entry output register, stamping the engine index into the
//               request tid. Cache responses are routed back by tid.
// Ports       : clk_i, rst_ni          - clock, async active-low reset
//               hwpf_req_valid_i/_o..  - per-engine request handshake
//               hwpf_req_i             - per-engine request (tid ignored)
//               hwpf_rsp_valid_o       - per-engine response strobe
//               hwpf_rsp_o             - response payload (broadcast)
//               hpdcache_req_*         - registered request to the cache
//               hpdcache_rsp_*         - response from the cache
//               tid_err_o              - sticky out-of-range response tid
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hwpf_stride_req_arb
    import hwpf_stride_pkg::*;
#(
    parameter hpdcache_cfg_t HPDcacheCfg     = HPDCACHE_CFG_DEFAULT,
    parameter int unsigned   NUM_HW_PREFETCH = HWPF_NUM_DEFAULT,
    parameter type           hpdcache_req_t  = hwpf_cache_req_t,
    parameter type           hpdcache_rsp_t  = hwpf_cache_rsp_t
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_HW_PREFETCH-1:0] hwpf_req_valid_i,
    output logic [NUM_HW_PREFETCH-1:0] hwpf_req_ready_o,
    input  hpdcache_req_t              hwpf_req_i [NUM_HW_PREFETCH],
    output logic [NUM_HW_PREFETCH-1:0] hwpf_rsp_valid_o,
    output hpdcache_rsp_t              hwpf_rsp_o,
    output logic                       hpdcache_req_valid_o,
    input  logic                       hpdcache_req_ready_i,
    output hpdcache_req_t              hpdcache_req_o,
    input  logic                       hpdcache_rsp_valid_i,
    input  hpdcache_rsp_t              hpdcache_rsp_i,
    output logic                       tid_err_o
);

    // NUM_HW_PREFETCH must lie in [1, 2**tidWidth] so every engine index
    // fits in the tid field.
    localparam int unsigned ID_W  = hwpf_id_width(NUM_HW_PREFETCH);
    localparam int unsigned TID_W = HPDcacheCfg.tidWidth;

    typedef logic [TID_W-1:0] tid_t;

    typedef enum logic [0:0] {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    buf_state_e                 state_q;
    buf_state_e                 state_d;
    hpdcache_req_t              req_q;
    hpdcache_req_t              req_d;
    logic                       tid_err_q;
    logic                       tid_err_d;

    logic                       w_can_load;
    logic                       w_accept;
    logic [NUM_HW_PREFETCH-1:0] w_gnt;
    logic [ID_W-1:0]            w_gnt_idx;
    logic                       w_tid_oob;

    // A slot is free when empty or when the held entry drains this cycle.
    // Gating with rst_ni keeps every ready low while reset is asserted.
    assign w_can_load = rst_ni & ((state_q == BUF_EMPTY) | hpdcache_req_ready_i);

    hwpf_stride_rr_arb #(
        .NUM_REQ (NUM_HW_PREFETCH),
        .IDX_W   (ID_W)
    ) u_rr_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (hwpf_req_valid_i),
        .en_i      (w_can_load),
        .gnt_o     (w_gnt),
        .gnt_idx_o (w_gnt_idx)
    );

    assign hwpf_req_ready_o = w_gnt;
    assign w_accept         = |w_gnt;

    // Output buffer next state: a load wins over a drain, which keeps the
    // slot full and sustains one request per cycle.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        if (w_accept) begin
            req_d     = hwpf_req_i[w_gnt_idx];
            req_d.tid = tid_t'(w_gnt_idx);
            state_d   = BUF_FULL;
        end else if ((state_q == BUF_FULL) && hpdcache_req_ready_i) begin
            state_d = BUF_EMPTY;
        end
    end

    assign w_tid_oob = 32'(hpdcache_rsp_i.tid) >= NUM_HW_PREFETCH;
    assign tid_err_d = tid_err_q | (hpdcache_rsp_valid_i & w_tid_oob);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= BUF_EMPTY;
            req_q     <= '0;
            tid_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            tid_err_q <= tid_err_d;
        end
    end

    assign hpdcache_req_valid_o = (state_q == BUF_FULL);
    assign hpdcache_req_o       = req_q;
    assign tid_err_o            = tid_err_q;

    // Zero-latency response demux; payload is broadcast to all engines.
    generate
        for (genvar i = 0; i < NUM_HW_PREFETCH; i++) begin : g_rsp_demux
            assign hwpf_rsp_valid_o[i] = hpdcache_rsp_valid_i &
                                         (hpdcache_rsp_i.tid == tid_t'(i));
        end
    endgenerate

    assign hwpf_rsp_o = hpdcache_rsp_i;

endmodule

`default_nettype wire

// File: tb/tb_hwpf_stride_req_arb.sv
// ============================================================================
// Module      : tb_hwpf_stride_req_arb
// Description : Self-checking bench for hwpf_stride_req_arb. A reference model
//               tracks the round-robin pointer and buffer occupancy, predicts
//               ready/response strobes every cycle and queues every expected
//               cache request; a monitor checks the cache port against that
//               queue whenever it presents a valid request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hwpf_stride_req_arb;
    import hwpf_stride_pkg::*;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b1;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    hwpf_cache_req_t req_in [N];
    logic [N-1:0]    rsp_valid_vec;
    hwpf_cache_rsp_t rsp_out;
    logic            c_valid;
    logic            c_ready;
    hwpf_cache_req_t c_req;
    logic            c_rsp_valid;
    hwpf_cache_rsp_t rsp_in;
    logic            tid_err;

    hwpf_stride_req_arb #(
        .HPDcacheCfg     (HPDCACHE_CFG_DEFAULT),
        .NUM_HW_PREFETCH (N),
        .hpdcache_req_t  (hwpf_cache_req_t),
        .hpdcache_rsp_t  (hwpf_cache_rsp_t)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_ni),
        .hwpf_req_valid_i     (req_valid),
        .hwpf_req_ready_o     (req_ready),
        .hwpf_req_i           (req_in),
        .hwpf_rsp_valid_o     (rsp_valid_vec),
        .hwpf_rsp_o           (rsp_out),
        .hpdcache_req_valid_o (c_valid),
        .hpdcache_req_ready_i (c_ready),
        .hpdcache_req_o       (c_req),
        .hpdcache_rsp_valid_i (c_rsp_valid),
        .hpdcache_rsp_i       (rsp_in),
        .tid_err_o            (tid_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    int              m_ptr;
    bit              m_full;
    bit              m_err;
    hwpf_cache_req_t exp_q[$];
    int              checks;
    int              errors;
    int              grant_cnt[N];
    bit              count_grants;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: whatever the cache port shows while valid must be
    // the oldest expected request; it retires on the handshake.
    always @(negedge clk) begin
        if (rst_ni && c_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL cache_req: valid with no expected request, got %0h at %0t", c_req, $time);
            end else begin
                if (c_req !== exp_q[0]) begin
                    errors++;
                    $display("FAIL cache_req: got %0h expected %0h at %0t", c_req, exp_q[0], $time);
                end
                if (c_ready) void'(exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus: drive after the edge, check the model's
    // combinational predictions at the falling edge, then advance the model.
    task automatic step(input logic [N-1:0] v, input bit crdy, input bit rv, input int rtid);
        bit              can_load;
        int              winner;
        int              e;
        logic [N-1:0]    exp_rdy;
        logic [N-1:0]    exp_rsp;
        hwpf_cache_req_t exp_req;
        for (int i = 0; i < N; i++) begin
            req_in[i].nline = HPDCACHE_NLINE_W'($urandom);
            req_in[i].op    = 2'($urandom);
            req_in[i].tid   = HPDCACHE_TID_W'($urandom);
        end
        req_valid   = v;
        c_ready     = crdy;
        c_rsp_valid = rv;
        rsp_in.tid  = HPDCACHE_TID_W'(rtid);
        rsp_in.data = $urandom;
        rsp_in.error = 1'($urandom);
        @(negedge clk);
        can_load = !m_full || crdy;
        winner   = -1;
        for (int k = 1; k <= N; k++) begin
            e = (m_ptr + k) % N;
            if (winner < 0 && v[e]) winner = e;
        end
        exp_rdy = '0;
        if (can_load && winner >= 0) exp_rdy[winner] = 1'b1;
        exp_rsp = '0;
        if (rv && rtid < N) exp_rsp[rtid] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("cache_valid", 64'(c_valid), 64'(m_full));
        check("rsp_valid", 64'(rsp_valid_vec), 64'(exp_rsp));
        check("rsp_payload", 64'(rsp_out), 64'(rsp_in));
        check("tid_err", 64'(tid_err), 64'(m_err));
        if (count_grants) begin
            for (int k = 0; k < N; k++) if (req_ready[k]) grant_cnt[k]++;
        end
        if (exp_rdy != '0) begin
            exp_req     = req_in[winner];
            exp_req.tid = HPDCACHE_TID_W'(winner);
            exp_q.push_back(exp_req);
            m_ptr  = winner;
            m_full = 1'b1;
        end else if (m_full && crdy) begin
            m_full = 1'b0;
        end
        if (rv && rtid >= N) m_err = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_full = 1'b0;
        m_ptr  = N - 1;
        m_err  = 1'b0;
    endtask

    // Hold reset for two edges with all engines requesting, check the idle
    // state, then release just after an edge.
    task automatic apply_reset();
        rst_ni      = 1'b0;
        req_valid   = '1;
        c_ready     = 1'b1;
        c_rsp_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_cache_valid", 64'(c_valid), 64'd0);
        check("rst_cache_req", 64'(c_req), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_tid_err", 64'(tid_err), 64'd0);
        rst_ni    = 1'b1;
        req_valid = '0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        count_grants = 1'b0;
        for (int i = 0; i < N; i++) begin
            grant_cnt[i] = 0;
            req_in[i]    = '0;
        end
        req_valid   = '0;
        c_ready     = 1'b0;
        c_rsp_valid = 1'b0;
        rsp_in      = '0;
        @(posedge clk);
        #1;
        apply_reset();

        // Single engine: ready in cycle 0, on the port in cycle 1, gone in 2.
        step(4'b0100, 1'b1, 1'b0, 0);
        step(4'b0000, 1'b1, 1'b0, 0);
        step(4'b0000, 1'b1, 1'b0, 0);

        // Sparse: park ptr on 0, then engines 0 and 3 alternate.
        step(4'b0001, 1'b1, 1'b0, 0);
        repeat (4) step(4'b1001, 1'b1, 1'b0, 0);

        // Back-pressure: fill, stall 5 cycles, then drain and reload together.
        step(4'b0010, 1'b1, 1'b0, 0);
        repeat (5) step(4'b1111, 1'b0, 1'b0, 0);
        step(4'b1111, 1'b1, 1'b0, 0);
        step(4'b0000, 1'b1, 1'b0, 0);

        // Fairness: 100 back-to-back grants spread evenly.
        count_grants = 1'b1;
        repeat (100) step(4'b1111, 1'b1, 1'b0, 0);
        count_grants = 1'b0;
        for (int i = 0; i < N; i++) check("fair_grants", 64'(grant_cnt[i]), 64'd25);

        // Directed response routing.
        step(4'b0000, 1'b1, 1'b1, 1);
        step(4'b0000, 1'b1, 1'b1, 3);
        step(4'b0000, 1'b1, 1'b1, 0);

        // Randomized traffic with in-range response tids.
        repeat (300) step(4'($urandom), $urandom_range(0, 3) != 0, 1'($urandom),
                          int'($urandom_range(0, N - 1)));

        // Out-of-range tid: no strobe, error flag from the next cycle, sticky.
        step(4'b0000, 1'b1, 1'b1, 5);
        step(4'b0000, 1'b1, 1'b0, 0);
        step(4'b0000, 1'b1, 1'b1, 7);
        step(4'b0000, 1'b1, 1'b0, 0);

        // Reset while stalled: valid must drop without waiting for a clock.
        step(4'b0100, 1'b1, 1'b0, 0);
        step(4'b1111, 1'b0, 1'b0, 0);
        req_valid = '1;
        c_ready   = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_valid", 64'(c_valid), 64'd0);
        check("async_rst_ready", 64'(req_ready), 64'd0);
        apply_reset();
        step(4'b1111, 1'b1, 1'b0, 0);
        step(4'b1111, 1'b1, 1'b0, 0);
        repeat (3) step(4'b0000, 1'b1, 1'b0, 0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hwpf_stride_req_arb.md
Name: hwpf_stride_req_arb

Overview:
Request arbiter and response router between N stride prefetcher engines and the single HPDcache prefetch requester port. It selects one pending engine request per cycle using round-robin and stamps the engine index into the request tid. The selected request goes through a one-entry output register. Responses from the cache are routed back to the owning engine by tid.

Parameters:
HPDcacheCfg, '0, HPDcache configuration (hpdcache_cfg_t); supplies the tid width.
NUM_HW_PREFETCH, 4, number of engines; must be >=1 and <=2^tidWidth.
hpdcache_req_t, logic, cache request type.
hpdcache_rsp_t, logic, cache response type.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
hwpf_req_valid_i  in  NUM_HW_PREFETCH  per-engine request valid
hwpf_req_ready_o  out  NUM_HW_PREFETCH  per-engine request accepted
hwpf_req_i  in  NUM_HW_PREFETCH x hpdcache_req_t  per-engine request (tid ignored)
hwpf_rsp_valid_o  out  NUM_HW_PREFETCH  per-engine response valid
hwpf_rsp_o  out  hpdcache_rsp_t  response payload, broadcast to all engines
hpdcache_req_valid_o  out  1  request to cache
hpdcache_req_ready_i  in  1  cache accepts request
hpdcache_req_o  out  hpdcache_req_t  registered request, tid = engine index
hpdcache_rsp_valid_i  in  1  cache response valid
hpdcache_rsp_i  in  hpdcache_rsp_t  cache response
tid_err_o  out  1  sticky flag: a response arrived with tid >= NUM_HW_PREFETCH

Behaviour:
- Reset values: hpdcache_req_valid_o=0; hpdcache_req_o=0; rr pointer=NUM_HW_PREFETCH-1, so engine 0 has first priority; tid_err_o=0. hwpf_req_ready_o=0 while reset is asserted.
- Output buffer is one entry, with states EMPTY and FULL.
  - can_load = EMPTY | (FULL & hpdcache_req_ready_i).
  - hpdcache_req_valid_o = FULL.
- Arbitration (combinational, each cycle):
  - Candidates are the engines with hwpf_req_valid_i=1.
  - The winner is the first candidate scanning from ptr+1 upward, wrapping modulo N.
  - hwpf_req_ready_o[winner] = can_load. All other ready bits are 0.
  - At most one ready bit is asserted per cycle.
- On accept (valid & ready):
  - The buffer loads hwpf_req_i[winner] with tid = winner, zero-extended. All other fields are unchanged.
  - ptr <= winner.
  - Buffer becomes FULL.
  - The request appears on hpdcache_req_o one cycle after acceptance (latency 1).
- Drain: FULL & hpdcache_req_ready_i & no new accept -> EMPTY.
- Simultaneous drain and load in the same cycle: the buffer stays FULL with the new request. This gives back-to-back throughput of 1 request per cycle.
- Back-pressure:
  - FULL & !hpdcache_req_ready_i -> every hwpf_req_ready_o = 0.
  - Buffer contents and ptr are held.
  - hpdcache_req_valid_o stays 1 and hpdcache_req_o stays stable until accepted (valid must never drop before ready).
- No candidate: ptr unchanged, nothing loaded.
- Engines may change or drop valid without being accepted. Arbitration is recomputed every cycle.
- Response routing is combinational, with 0 latency:
  - hwpf_rsp_valid_o[i] = hpdcache_rsp_valid_i & (hpdcache_rsp_i.tid == i).
  - hwpf_rsp_o = hpdcache_rsp_i.
  - There is no back-pressure on responses.
- tid >= NUM_HW_PREFETCH with rsp_valid: no engine valid is raised, and tid_err_o is set at the next edge. It stays set until reset.
- Reset mid-operation: the buffered request is discarded, and the engines' inflight counters are reset by the same rst_ni.
- NUM_HW_PREFETCH=1: ptr is constant and the block degenerates to a pipeline register with tid 0.

Decomposition:
- hwpf_stride_pkg:
  - localparam for the default NUM_HW_PREFETCH.
  - typedef hwpf_engine_id_t, width $clog2(max(NUM_HW_PREFETCH,2)).
- One sub-module, hwpf_stride_rr_arb: generic N-way round-robin arbiter.
  - Inputs: req vector, enable (= can_load).
  - Outputs: one-hot gnt, gnt index.
  - It owns the pointer register and updates it only when enable & |req.
- The top level holds the output buffer, tid stamping, response demux and the error flag.

Test Plan:
- Single engine: engine 2 valid with nline X, cache ready=1 -> ready_o[2]=1 at cycle 0; hpdcache_req_valid_o=1 with tid=2 and addr for X at cycle 1; valid=0 at cycle 2.
- Fairness: all 4 engines permanently valid, cache ready=1 -> accepted tids cycle through 0,1,2,3,0,1,... and each engine gets exactly 25 grants in 100 cycles.
- Back-pressure: buffer FULL and cache ready held 0 for 5 cycles -> all ready_o=0, hpdcache_req_o unchanged for 5 cycles; ready=1 -> drained, and the next winner loads in the same cycle.
- Response routing: rsp_valid with tid=1, then tid=3 -> only hwpf_rsp_valid_o[1], then only [3], pulse in the same cycle; tid=5 with N=4 -> no valid out and tid_err_o=1 from the next cycle on.
- Sparse requests: engines 0 and 3 valid, ptr=0 -> engine 3 wins; next cycle engine 0 wins; engines 1 and 2 never get a ready.
- Reset mid-stall: FULL, cache ready=0, assert rst_ni=0 -> hpdcache_req_valid_o=0 immediately (asynchronous); after release, engine 0 has priority.
